// File: rtl/icache_ctrl.sv
// ----------------------------------------------------------------------------
// icache_ctrl
// Direct-mapped instruction cache with a two-state miss handler. Hits return
// one instruction per cycle; a miss stalls fetch, refills the whole line from
// instruction memory, installs it and returns the requested instruction.
//
// Optional feature macro: ICACHE_STATS_EN (adds hit_count / miss_count).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid, req_addr   fetch request (byte address)
//   req_ready             high while IDLE
//   resp_valid/resp_instr one-cycle response pulse and instruction
//   flush                 invalidate every line
//   mem_req/mem_addr      line refill request, line-aligned address
//   mem_ack/mem_rdata     single-cycle acknowledge with full line data
//   hit_count/miss_count  saturating statistics (ICACHE_STATS_EN only)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | accepting lookups; hits answered the cycle after sampling
// REFILL | line request outstanding; waiting for mem_ack
// ----------------------------------------------------------------------------
module icache_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16,
    parameter int WORDS   = 4,
    parameter int LINES   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    input  logic [ADDR_W-1:0]          req_addr,
    output logic                       req_ready,
    output logic                       resp_valid,
    output logic [INSTR_W-1:0]         resp_instr,
    input  logic                       flush,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_ack,
    input  logic [INSTR_W*WORDS-1:0]   mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]                hit_count,
    output logic [31:0]                miss_count
`endif
);

    localparam int B      = $clog2(INSTR_W / 8);
    localparam int W      = $clog2(WORDS);
    localparam int I      = $clog2(LINES);
    localparam int OFF    = B + W;
    localparam int TAG_W  = ADDR_W - B - W - I;
    localparam int LINE_W = INSTR_W * WORDS;

    typedef enum logic {IDLE = 1'b0, REFILL = 1'b1} state_t;

    state_t             state;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [LINE_W-1:0]  data_mem [LINES];
    logic [W-1:0]       miss_word;

    logic [W-1:0]       req_word;
    logic [I-1:0]       req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [I-1:0]       miss_idx;
    logic [TAG_W-1:0]   miss_tag;
    logic               hit;
    logic [INSTR_W-1:0] hit_word;
    logic [INSTR_W-1:0] fill_word;
    logic [ADDR_W-1:0]  line_addr;
    logic               unused_addr;

    assign req_word  = req_addr[B +: W];
    assign req_idx   = req_addr[OFF +: I];
    assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
    // The outstanding line address doubles as the install index/tag.
    assign miss_idx  = mem_addr[OFF +: I];
    assign miss_tag  = mem_addr[ADDR_W-1 -: TAG_W];
    assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign hit_word  = data_mem[req_idx][int'(req_word) * INSTR_W +: INSTR_W];
    assign fill_word = mem_rdata[int'(miss_word) * INSTR_W +: INSTR_W];
    assign line_addr = {req_tag, req_idx, {OFF{1'b0}}};
    assign req_ready = (state == IDLE);
    // Byte-offset bits are intentionally ignored.
    assign unused_addr = ^req_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            valid      <= '0;
            resp_valid <= 1'b0;
            resp_instr <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            miss_word  <= '0;
`ifdef ICACHE_STATS_EN
            hit_count  <= '0;
            miss_count <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        // A flush in the same cycle forces the lookup to miss.
                        if (hit && !flush) begin
                            resp_valid <= 1'b1;
                            resp_instr <= hit_word;
`ifdef ICACHE_STATS_EN
                            if (hit_count != '1) hit_count <= hit_count + 32'd1;
`endif
                        end else begin
                            mem_req   <= 1'b1;
                            mem_addr  <= line_addr;
                            miss_word <= req_word;
                            state     <= REFILL;
`ifdef ICACHE_STATS_EN
                            if (miss_count != '1) miss_count <= miss_count + 32'd1;
`endif
                        end
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        valid[miss_idx] <= 1'b1;
                        resp_valid      <= 1'b1;
                        resp_instr      <= fill_word;
                        mem_req         <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Placed last so a coincident mem_ack cannot leave its line valid.
            if (flush) valid <= '0;
        end
    end

    // Tag and data arrays carry no reset; validity alone qualifies them.
    always_ff @(posedge clk) begin
        if (state == REFILL && mem_ack) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [15:0] resp_instr;
    logic        flush;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [63:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] LINE_A = 64'h4444_3333_2222_1111;
    localparam logic [63:0] LINE_B = 64'hDDDD_CCCC_BBBB_AAAA;

    always #5 clk = ~clk;

    icache_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_instr (resp_instr),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #12;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_instr", 64'(resp_instr), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        rst_n = 1'b1;
        tick();

        // Cold miss on 0x0040, ack three cycles after the request edge
        req_valid = 1'b1; req_addr = 16'h0040;
        tick();
        chk("cold_mem_req", 64'(mem_req), 64'd1);
        chk("cold_mem_addr", 64'(mem_addr), 64'h0040);
        chk("cold_no_resp", 64'(resp_valid), 64'd0);
        chk("cold_ready_low", 64'(req_ready), 64'd0);
        req_valid = 1'b0;
        tick();
        tick();
        chk("cold_req_held", 64'(mem_req), 64'd1);
        chk("cold_addr_held", 64'(mem_addr), 64'h0040);
        mem_ack = 1'b1; mem_rdata = LINE_A;
        tick();
        chk("cold_resp_valid", 64'(resp_valid), 64'd1);
        chk("cold_resp_instr", 64'(resp_instr), 64'h1111);
        chk("cold_req_drop", 64'(mem_req), 64'd0);
        chk("cold_ready_back", 64'(req_ready), 64'd1);
        mem_ack = 1'b0; mem_rdata = '0;
        tick();
        chk("cold_pulse_one", 64'(resp_valid), 64'd0);

        // Back-to-back hits on the rest of the line
        req_valid = 1'b1; req_addr = 16'h0042;
        tick();
        chk("hit1_valid", 64'(resp_valid), 64'd1);
        chk("hit1_instr", 64'(resp_instr), 64'h2222);
        req_addr = 16'h0044;
        tick();
        chk("hit2_valid", 64'(resp_valid), 64'd1);
        chk("hit2_instr", 64'(resp_instr), 64'h3333);
        req_addr = 16'h0046;
        tick();
        chk("hit3_valid", 64'(resp_valid), 64'd1);
        chk("hit3_instr", 64'(resp_instr), 64'h4444);
        chk("hit_no_mem_req", 64'(mem_req), 64'd0);
        req_valid = 1'b0;
        tick();
        chk("hit_idle_resp", 64'(resp_valid), 64'd0);
`ifdef ICACHE_STATS_EN
        chk("stats_hits", 64'(hit_count), 64'd3);
        chk("stats_misses", 64'(miss_count), 64'd1);
`endif

        // Conflict: 0x0084 maps to index 0 with tag 2, word 2 of the line
        req_valid = 1'b1; req_addr = 16'h0084;
        tick();
        chk("conf_mem_req", 64'(mem_req), 64'd1);
        chk("conf_mem_addr", 64'(mem_addr), 64'h0080);
        req_valid = 1'b0;
        mem_ack = 1'b1; mem_rdata = LINE_B;
        tick();
        chk("conf_resp_valid", 64'(resp_valid), 64'd1);
        chk("conf_resp_instr", 64'(resp_instr), 64'hCCCC);
        mem_ack = 1'b0;
        req_valid = 1'b1; req_addr = 16'h0040;
        tick();
        chk("evict_miss", 64'(mem_req), 64'd1);
        chk("evict_addr", 64'(mem_addr), 64'h0040);
        chk("evict_no_resp", 64'(resp_valid), 64'd0);
        req_valid = 1'b0;
        mem_ack = 1'b1; mem_rdata = LINE_A;
        tick();
        chk("evict_fill_instr", 64'(resp_instr), 64'h1111);
        // Ack while IDLE must be ignored
        tick();
        chk("idle_ack_no_resp", 64'(resp_valid), 64'd0);
        chk("idle_ack_no_req", 64'(mem_req), 64'd0);
        mem_ack = 1'b0;

        // Flush pulse, then lookup of the resident line misses
        flush = 1'b1;
        tick();
        flush = 1'b0;
        req_valid = 1'b1; req_addr = 16'h0040;
        tick();
        chk("flush_miss", 64'(mem_req), 64'd1);
        chk("flush_no_resp", 64'(resp_valid), 64'd0);
        req_valid = 1'b0;
        // Flush together with ack: response returned, line left invalid
        flush = 1'b1; mem_ack = 1'b1; mem_rdata = LINE_A;
        tick();
        chk("flush_ack_resp", 64'(resp_valid), 64'd1);
        chk("flush_ack_instr", 64'(resp_instr), 64'h1111);
        flush = 1'b0; mem_ack = 1'b0;
        req_valid = 1'b1; req_addr = 16'h0040;
        tick();
        chk("flush_ack_remiss", 64'(mem_req), 64'd1);
        req_valid = 1'b0;
        // Flush mid-refill does not abort; the later fill stays valid
        flush = 1'b1;
        tick();
        chk("flush_refill_held", 64'(mem_req), 64'd1);
        flush = 1'b0; mem_ack = 1'b1;
        tick();
        chk("flush_refill_resp", 64'(resp_instr), 64'h1111);
        mem_ack = 1'b0;
        req_valid = 1'b1; req_addr = 16'h0044;
        tick();
        chk("post_refill_hit", 64'(resp_valid), 64'd1);
        chk("post_refill_instr", 64'(resp_instr), 64'h3333);
        // Flush coinciding with a lookup forces a miss
        req_addr = 16'h0042; flush = 1'b1;
        tick();
        chk("flush_lookup_miss", 64'(mem_req), 64'd1);
        chk("flush_lookup_noresp", 64'(resp_valid), 64'd0);
        req_valid = 1'b0; flush = 1'b0;
        mem_ack = 1'b1;
        tick();
        chk("flush_lookup_instr", 64'(resp_instr), 64'h2222);
        mem_ack = 1'b0;

        // Reset while a refill is outstanding
        req_valid = 1'b1; req_addr = 16'h0080;
        tick();
        chk("rst_mid_req", 64'(mem_req), 64'd1);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_drop", 64'(mem_req), 64'd0);
        chk("rst_mid_ready", 64'(req_ready), 64'd1);
        #1;
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = LINE_B;
        tick();
        chk("stray_ack_noresp", 64'(resp_valid), 64'd0);
        chk("stray_ack_ready", 64'(req_ready), 64'd1);
        chk("stray_ack_noreq", 64'(mem_req), 64'd0);
        mem_ack = 1'b0;
`ifdef ICACHE_STATS_EN
        chk("stats_rst_hits", 64'(hit_count), 64'd0);
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Parametrised direct-mapped instruction cache with an integrated miss-handling state machine and a line-refill handshake to instruction memory. It sits between the fetch stage and instruction memory. It returns one instruction per cycle on hits. On a miss it stalls fetch, requests the whole line, installs it, and returns the requested instruction. It adds reset, flush, back-pressure and configurable geometry.

## Interface
Parameters:
- ADDR_W, 16, byte address width.
- INSTR_W, 16, instruction width in bits; multiple of 8, and INSTR_W/8 must be a power of two.
- WORDS, 4, instructions per line; power of two, at least 2.
- LINES, 8, number of lines; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request present.
- req_addr  in  ADDR_W  byte address of the instruction.
- req_ready  out  1  cache can accept a request; combinational, equal to (state==IDLE).
- resp_valid  out  1  one-cycle pulse; resp_instr is valid in that cycle.
- resp_instr  out  INSTR_W  returned instruction.
- flush  in  1  invalidate all lines.
- mem_req  out  1  line refill request; held until acknowledged.
- mem_addr  out  ADDR_W  line-aligned refill address; offset bits are zero.
- mem_ack  in  1  single-cycle acknowledge; mem_rdata is valid in the same cycle.
- mem_rdata  in  INSTR_W*WORDS  full line; word 0 is in the least-significant bits.

## Operation
- Address split, with B=log2(INSTR_W/8), W=log2(WORDS), I=log2(LINES):
  - byte offset is [B-1:0] and is ignored;
  - word select is [B+W-1:B];
  - index is [B+W+I-1:B+W];
  - tag is the remaining upper bits.
- Storage: per line one valid bit, one tag and INSTR_W*WORDS data bits, all registered.
- States are IDLE and REFILL.
- IDLE, when req_valid is sampled high:
  - Hit means valid[index] and tag match. On a hit: resp_valid=1, resp_instr=selected word, stay in IDLE.
  - On a miss: capture req_addr, set mem_req=1 and mem_addr={tag,index,0}, go to REFILL. No response is given that cycle.
- REFILL: req_ready=0, and req_valid is ignored. mem_req and mem_addr are held stable until mem_ack is sampled. On mem_ack:
  - write mem_rdata, tag and valid=1 into the line;
  - resp_valid=1, resp_instr = selected word taken directly from mem_rdata;
  - mem_req=0, return to IDLE.
- The replacement victim is always the indexed line; lines hold clean instructions only, so there is no writeback.
- flush sampled high: all valid bits are cleared at that edge.
  - If flush coincides with an IDLE lookup, that lookup is treated as a miss.
  - If flush coincides with mem_ack, flush wins: the line is not marked valid, but the response is still returned.
  - During REFILL, flush does not abort the refill.
- resp_valid is low in every cycle not listed above.

## Timing
- Reset (asynchronous): state=IDLE; all valid bits=0; resp_valid=0; resp_instr=0; mem_req=0; mem_addr=0. Data and tag arrays are not reset.
- Reset asserted during REFILL drops mem_req immediately. A later mem_ack is ignored.
- Hit latency: request sampled at edge N gives resp_valid high after edge N. Back-to-back hits give one response per cycle.
- Miss latency: request sampled at edge N gives mem_req high after N. With mem_ack sampled at edge N+k, resp_valid is high after N+k and req_ready returns high in the same cycle.
- mem_ack sampled in IDLE is ignored.

## Configuration
- ICACHE_STATS_EN defined: adds output ports hit_count[31:0] and miss_count[31:0].
  - hit_count increments on each IDLE hit; miss_count increments on each IDLE-to-REFILL transition.
  - Both counters saturate at 0xFFFFFFFF.
  - Both are cleared only by reset, not by flush.
- ICACHE_STATS_EN undefined: the two ports and the counters are absent; all other behaviour is identical.

## Test plan
Default parameters throughout.
- Cold miss: after reset, request 0x0040 → mem_req=1, mem_addr=0x0040. Ack 3 cycles later with mem_rdata=0x4444_3333_2222_1111 → resp_instr=0x1111, one-cycle resp_valid.
- Hit pipeline: then requests 0x0042, 0x0044, 0x0046 on consecutive cycles → responses 0x2222, 0x3333, 0x4444 on consecutive cycles, mem_req stays 0.
- Conflict: request 0x0080 (index 0, tag 2) → miss and refill; then request 0x0040 → miss again, with mem_addr=0x0040.
- Flush: with line 0x0040 resident, pulse flush, then request 0x0040 → miss. Also drive flush and mem_ack in the same cycle → response returned, and the next request to the same address still misses.
- Reset mid-refill: deassert rst_n while mem_req=1 → mem_req=0 immediately. A stray mem_ack afterwards produces no resp_valid, and req_ready=1.
- Stats (ICACHE_STATS_EN defined): running the first two scenarios gives hit_count=3, miss_count=1.
